// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative MULT/MULTU/DIV/DIVU sequencer for the HI/LO datapath.
// Radix-2 shift-add multiplier and restoring divider, one iteration per cycle.
// Optional MULT_DIV_EARLY_ZERO_EN: zero-operand multiply or zero-divisor divide skips RUN.
module mult_div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  flush,
    output logic                  stall_pipeline,
    output logic                  busy,
    output logic                  hi_lo_register_write,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q;
    logic [1:0]    op_q;
    logic          sa_q, sb_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  acc_hi_q, acc_lo_q, b_q, hi_q, lo_q;
    logic          sa_d, sb_d, borrow, launch, fin, early;
    logic [W-1:0]  abs_a, abs_b, step_hi, step_lo, res_hi, res_lo;
    logic [W:0]    sum, sh;
    logic [2*W-1:0] prod_c;

    // Operand magnitudes, one iteration step and final sign correction
    always_comb begin
        sa_d    = ~op[0] & operand_a[W-1];
        sb_d    = ~op[0] & operand_b[W-1];
        abs_a   = sa_d ? -operand_a : operand_a;
        abs_b   = sb_d ? -operand_b : operand_b;
        sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        sh      = {acc_hi_q, acc_lo_q[W-1]};
        borrow  = sh < {1'b0, b_q};
        step_hi = op_q[1] ? (borrow ? sh[W-1:0] : sh[W-1:0] - b_q) : sum[W:1];
        step_lo = op_q[1] ? {acc_lo_q[W-2:0], ~borrow} : {sum[0], acc_lo_q[W-1:1]};
        prod_c  = (sa_q ^ sb_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        res_hi  = op_q[1] ? (sa_q ? -acc_hi_q : acc_hi_q) : prod_c[2*W-1:W];
        res_lo  = op_q[1] ? ((sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q) : prod_c[W-1:0];
        launch  = state_q == IDLE && start && !flush;
        fin     = state_q == DONE && !flush;
`ifdef MULT_DIV_EARLY_ZERO_EN
        early   = op[1] ? operand_b == '0 : (operand_a == '0 || operand_b == '0);
`else
        early   = 1'b0;
`endif
    end

    assign stall_pipeline       = (state_q == IDLE && start) || state_q == RUN;
    assign busy                 = state_q != IDLE;
    assign hi_lo_register_write = fin;
    assign hi_out               = fin ? res_hi : hi_q;
    assign lo_out               = fin ? res_lo : lo_q;

    // Sequencer FSM with accumulators; multiply keeps multiplier in acc_lo, divide keeps quotient there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (launch) begin
                    op_q     <= op;
                    sa_q     <= sa_d;
                    sb_q     <= sb_d;
                    cnt_q    <= CW'(W - 1);
                    b_q      <= op[1] ? abs_b : abs_a;
                    acc_hi_q <= (early && op[1]) ? abs_a : '0;
                    acc_lo_q <= early ? (op[1] ? '1 : '0) : (op[1] ? abs_a : abs_b);
                    state_q  <= early ? DONE : RUN;
                end
                RUN: if (flush) begin
                    state_q <= IDLE;
                end else begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    if (!flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: directed vectors against an arithmetic reference model of mult_div_sequencer.
module tb_mult_div_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic        stall_pipeline, busy, hi_lo_register_write;
    logic [31:0] hi_out, lo_out;
    int          total = 0, bad = 0;

    mult_div_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .stall_pipeline(stall_pipeline), .busy(busy),
        .hi_lo_register_write(hi_lo_register_write),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: {HI, LO} from plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] ua, ub, q, r;
        logic        na, nb;
        na = !o[0] && a[31];
        nb = !o[0] && b[31];
        ua = na ? 32'd0 - a : a;
        ub = nb ? 32'd0 - b : b;
        if (!o[1]) begin
            if (!o[0]) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else       p = {32'd0, a} * {32'd0, b};
        end else begin
            if (ub == 0) begin q = 32'hFFFFFFFF; r = ua; end
            else begin q = ua / ub; r = ua % ub; end
            if (na ^ nb) q = 32'd0 - q;
            if (na) r = 32'd0 - r;
            p = {r, q};
        end
        return p;
    endfunction

    function automatic int lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_DIV_EARLY_ZERO_EN
        if (o[1] ? b == 0 : (a == 0 || b == 0)) return 1;
`endif
        return 33;
    endfunction

    // Cycle-level model: cycles left until and including the commit cycle, plus committed HI/LO
    int          m_left = 0;
    logic [63:0] m_res = '0, m_held = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_res  <= '0;
            m_held <= '0;
        end else if (m_left == 0) begin
            if (start && !flush) begin
                m_left <= lat(op, operand_a, operand_b);
                m_res  <= model(op, operand_a, operand_b);
            end
        end else if (flush) begin
            m_left <= 0;
        end else begin
            if (m_left == 1) m_held <= m_res;
            m_left <= m_left - 1;
        end
    end

    // Compare all outputs against the model every cycle
    always @(negedge clk) begin
        if (!reset) begin
            logic        e_wr;
            logic [63:0] e_v;
            e_wr = m_left == 1 && !flush;
            e_v  = e_wr ? m_res : m_held;
            chk("stall", 32'(stall_pipeline), 32'((m_left == 0 && start) || m_left > 1));
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("wr", 32'(hi_lo_register_write), 32'(e_wr));
            chk("hi", hi_out, e_v[63:32]);
            chk("lo", lo_out, e_v[31:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int el, input logic [31:0] eh, input logic [31:0] elo);
        int cyc = c0;
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (hi_lo_register_write) seen = 1;
            else begin tick(); cyc++; end
        end
        chk("strobe_seen", 32'(seen), 32'd1);
        chk("latency", cyc, el);
        chk("res_hi", hi_out, eh);
        chk("res_lo", lo_out, elo);
        tick();
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        tick();
    endtask

    localparam int N = 10;
    logic [1:0]  t_op [N] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11};
    logic [31:0] t_a  [N] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000, 32'd100,
                              32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'd7, 32'd50};
    logic [31:0] t_b  [N] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'hFFFFFFFF, 32'd0,
                              32'd0, 32'd12345, 32'd10, 32'hFFFFFFF8, 32'd7};
    logic [31:0] t_hi [N] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h64,
                              32'hFFFFFFF9, 32'h0, 32'h5, 32'hFFFFFFFF, 32'h1};
    logic [31:0] t_lo [N] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                              32'h00000001, 32'h0, 32'h19999999, 32'hFFFFFFC8, 32'h7};

    initial begin
        logic [63:0] mv;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(hi_lo_register_write), 32'd0);
        chk("rst_stall", 32'(stall_pipeline), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            mv = model(t_op[i], t_a[i], t_b[i]);
            chk("model_pin", mv[63:32], t_hi[i]);
            chk("model_pin", mv[31:0], t_lo[i]);
            go(t_op[i], t_a[i], t_b[i]);
            wait_done(1, lat(t_op[i], t_a[i], t_b[i]), t_hi[i], t_lo[i]);
        end
        chk("lat_pin", lat(2'b01, 32'd3, 32'd4), 32'd33);

        // Start while busy is ignored
        go(2'b01, 32'd3, 32'd3);
        repeat (4) tick();
        start = 1'b1; op = 2'b11; operand_a = 32'd9; operand_b = 32'd0;
        tick();
        start = 1'b0;
        wait_done(6, 33, 32'd0, 32'd9);

        // Flush in RUN at cycle 10, restart at cycle 11
        go(2'b11, 32'd50, 32'd7);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b1; op = 2'b11; operand_a = 32'd50; operand_b = 32'd7;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_hi", hi_out, 32'd0);
        chk("flush_lo", lo_out, 32'd9);
        tick();
        start = 1'b0;
        wait_done(1, 33, 32'd1, 32'd7);

        // Flush in DONE suppresses the commit
        go(2'b01, 32'd6, 32'd7);
        repeat (32) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("dflush_wr", 32'(hi_lo_register_write), 32'd0);
        chk("dflush_lo", lo_out, 32'd7);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("dflush_busy", 32'(busy), 32'd0);
        chk("dflush_hi", hi_out, 32'd1);
        tick();

        // Asynchronous reset mid-operation at cycle 15
        go(2'b01, 32'd6, 32'd7);
        repeat (14) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_hi", hi_out, 32'd0);
        chk("arst_lo", lo_out, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr", 32'(hi_lo_register_write), 32'd0);
        chk("arst_stall", 32'(stall_pipeline), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        tick();
        go(2'b01, 32'd6, 32'd7);
        wait_done(1, 33, 32'd0, 32'h2A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
